sprite_commit_buffer: RTL and testbench

Upstream feeder for `doodle_renderer`'s sprite table. The CPU writes a full frame's sprite list into a private shadow table at any time, then issues a commit. The block waits for the next vertical-blank rising edge and bursts all 32 entries into the renderer's write port, one per clock. The renderer therefore never shows a half-updated frame.

---
 rtl/doodle_gfx_pkg.sv | 38 +++
 rtl/sprite_shadow_ram.sv | 51 +++++
 rtl/sprite_commit_buffer.sv | 195 +++++++++++++++++++
 tb/tb_sprite_commit_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_gfx_pkg.sv
// Shared definitions for the doodle graphics blocks: sprite entry layout,
// table depth, CPU CTRL/STATUS bit positions and the commit-buffer states.
package doodle_gfx_pkg;

  localparam int ENTRIES = 32;
  localparam int ENTRY_W = 26;

  localparam int TYPE_HI = 25;
  localparam int TYPE_LO = 22;
  localparam int X_HI    = 21;
  localparam int X_LO    = 11;
  localparam int Y_HI    = 10;
  localparam int Y_LO    = 0;

  // Word-address bit that separates the shadow table from CTRL/STATUS
  localparam int ADDR_CTRL_BIT = 5;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_OVR = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_AGAIN   = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_FCNT_LO = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VBL = 2'd1,
    COPY     = 2'd2
  } copy_state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [3:0] spriteType,
                                                    input logic [10:0] xPos,
                                                    input logic [10:0] yPos);
    return {spriteType, xPos, yPos};
  endfunction

endpackage

// File: rtl/sprite_shadow_ram.sv
// CPU-side shadow copy of the sprite table: one write port and two
// synchronous read ports (CPU readback and burst copy). The CPU port is
// read-first; the copy port forwards a same-cycle write so that a write
// landing in the blank-edge cycle still makes it into the burst.
module sprite_shadow_ram
  import doodle_gfx_pkg::*;
#(
  parameter int DEPTH = ENTRIES,
  parameter int WIDTH = ENTRY_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    cpu_raddr_i,
  output logic [WIDTH-1:0] cpu_rdata_o,
  input  logic [AW-1:0]    cp_raddr_i,
  output logic [WIDTH-1:0] cp_rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] cpuRdata_q;
  logic [WIDTH-1:0] cpRdata_q;

  // Storage array plus both registered read ports; reset empties every slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cpuRdata_q <= '0;
      cpRdata_q  <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      cpuRdata_q <= mem_q[cpu_raddr_i];
      if (we_i && (waddr_i == cp_raddr_i)) begin
        cpRdata_q <= wdata_i;
      end else begin
        cpRdata_q <= mem_q[cp_raddr_i];
      end
    end
  end

  assign cpu_rdata_o = cpuRdata_q;
  assign cp_rdata_o  = cpRdata_q;

endmodule

// File: rtl/sprite_commit_buffer.sv
// Double-buffers the renderer's sprite table: the CPU fills a shadow table,
// commits, and the whole table is burst into the renderer on the next
// vblank rising edge so a frame never shows a half-updated sprite list.
// Optional feature macro: SPRITE_DIRTY_SKIP_EN (skip renderer writes for
// slots not written since their last copy; the burst length is unchanged).
module sprite_commit_buffer
  import doodle_gfx_pkg::*;
#(
  parameter int ENTRIES = doodle_gfx_pkg::ENTRIES,
  parameter int ENTRY_W = doodle_gfx_pkg::ENTRY_W,
  parameter int FCNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic        cpu_we,
  output logic [31:0] cpu_dout,
  input  logic        vblank,
  output logic [31:0] r_addr,
  output logic [31:0] r_din,
  output logic        r_we,
  output logic        busy
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

  copy_state_e         state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                again_q, again_d;
  logic                overrun_q, overrun_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                vblank_q;
  logic                rWe_q, rWe_d;
  logic [IDX_BITS-1:0] rAddr_q, rAddr_d;
  logic                busy_q;
  logic [31:0]         status_q, statusWord;
  logic                readShadow_q, readStatus_q;

  logic                vblankRise;
  logic                selShadow, selCtrl;
  logic                writeAccept, writeDrop;
  logic                commit, clrOverrun;
  logic                beatEn;
  logic [IDX_BITS-1:0] cpRaddr;
  logic [ENTRY_W-1:0]  shadowCpuData, shadowCpData;
  logic                unusedBits;

  assign vblankRise  = vblank & ~vblank_q;
  assign selShadow   = ~cpu_addr[ADDR_CTRL_BIT];
  assign selCtrl     = cpu_addr[ADDR_CTRL_BIT] & (cpu_addr[IDX_BITS-1:0] == '0);
  assign writeAccept = cpu_we & selShadow & (state_q != COPY);
  assign writeDrop   = cpu_we & selShadow & (state_q == COPY);
  assign commit      = cpu_we & selCtrl & cpu_din[CTRL_COMMIT];
  assign clrOverrun  = cpu_we & selCtrl & cpu_din[CTRL_CLR_OVR];
  assign unusedBits  = ^{cpu_addr[31:ADDR_CTRL_BIT+1], cpu_din[31:ENTRY_W]};

  // The copy port is addressed one beat ahead so its registered output lines up with r_addr
  assign cpRaddr = (state_q == COPY) ? idx_q + 1'b1 : '0;

  sprite_shadow_ram #(
    .DEPTH (ENTRIES),
    .WIDTH (ENTRY_W),
    .AW    (IDX_BITS)
  ) u_shadow (
    .clk_i       (clk),
    .rst_i       (rst),
    .we_i        (writeAccept),
    .waddr_i     (cpu_addr[IDX_BITS-1:0]),
    .wdata_i     (cpu_din[ENTRY_W-1:0]),
    .cpu_raddr_i (cpu_addr[IDX_BITS-1:0]),
    .cpu_rdata_o (shadowCpuData),
    .cp_raddr_i  (cpRaddr),
    .cp_rdata_o  (shadowCpData)
  );

  // Commit/copy sequencing, pending re-commit and committed-frame counting
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    again_d = again_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (commit) state_d = WAIT_VBL;
      end
      WAIT_VBL: begin
        if (vblankRise) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY: begin
        idx_d = idx_q + 1'b1;
        if (commit) again_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = (again_q || commit) ? WAIT_VBL : IDLE;
          again_d = 1'b0;
          fcnt_d  = fcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overrun: a shadow write dropped mid-burst, cleared only by the CPU
  always_comb begin
    overrun_d = overrun_q;
    if (writeDrop) begin
      overrun_d = 1'b1;
    end else if (clrOverrun) begin
      overrun_d = 1'b0;
    end
  end

`ifdef SPRITE_DIRTY_SKIP_EN
  logic [ENTRIES-1:0] dirty_q, dirty_d;

  // Track slots written since their last copy; a beat fires only for dirty slots and cleans them
  always_comb begin
    dirty_d = dirty_q;
    beatEn  = 1'b0;
    if (writeAccept) dirty_d[cpu_addr[IDX_BITS-1:0]] = 1'b1;
    if ((state_d == COPY) && dirty_d[idx_d]) begin
      beatEn         = 1'b1;
      dirty_d[idx_d] = 1'b0;
    end
  end

  // Dirty mask register; reset marks everything dirty so the first burst clears the renderer
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= '1;
    end else begin
      dirty_q <= dirty_d;
    end
  end
`else
  assign beatEn = (state_d == COPY);
`endif

  // Renderer port values for the next cycle; r_addr keeps sweeping even for skipped beats
  always_comb begin
    rWe_d   = beatEn;
    rAddr_d = (state_d == COPY) ? idx_d : rAddr_q;
  end

  // STATUS word assembled from the current register values
  always_comb begin
    statusWord                           = '0;
    statusWord[STAT_BUSY]                = busy_q;
    statusWord[STAT_AGAIN]               = again_q;
    statusWord[STAT_OVERRUN]             = overrun_q;
    statusWord[STAT_FCNT_LO +: FCNT_W]   = fcnt_q;
  end

  // All state and output registers; reset leaves an implicit commit pending
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_VBL;
      idx_q        <= '0;
      again_q      <= 1'b0;
      overrun_q    <= 1'b0;
      fcnt_q       <= '0;
      vblank_q     <= 1'b1;
      rWe_q        <= 1'b0;
      rAddr_q      <= '0;
      busy_q       <= 1'b1;
      status_q     <= '0;
      readShadow_q <= 1'b0;
      readStatus_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      again_q      <= again_d;
      overrun_q    <= overrun_d;
      fcnt_q       <= fcnt_d;
      vblank_q     <= vblank;
      rWe_q        <= rWe_d;
      rAddr_q      <= rAddr_d;
      busy_q       <= (state_d != IDLE);
      status_q     <= statusWord;
      readShadow_q <= selShadow;
      readStatus_q <= selCtrl;
    end
  end

  assign cpu_dout = readShadow_q ? 32'(shadowCpuData) : (readStatus_q ? status_q : 32'd0);
  assign r_addr   = 32'(rAddr_q);
  assign r_din    = 32'(shadowCpData);
  assign r_we     = rWe_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sprite_commit_buffer.sv
// Directed bench for sprite_commit_buffer: reset burst, slot data routing,
// mid-blank commit, overrun, commit during copy, reset abort and (when
// SPRITE_DIRTY_SKIP_EN is defined) dirty-slot skipping.
`timescale 1ns/1ps
module tb_sprite_commit_buffer;

  localparam logic [31:0] CTRL_ADDR = 32'h0000_0020;
`ifdef SPRITE_DIRTY_SKIP_EN
  localparam bit DIRTY_MODE = 1'b1;
`else
  localparam bit DIRTY_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic        cpu_we;
  logic [31:0] cpu_dout;
  logic        vblank;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic        r_we;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  int          beatCount;
  int          firstBeat;
  logic [31:0] beatAddr [64];
  logic [31:0] beatData [64];
  logic        seenValid [32];
  logic [31:0] seenData [32];
  logic        busyAt32;
  logic        busyAt33;
  logic [31:0] midStatus;

  sprite_commit_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_dout (cpu_dout),
    .vblank   (vblank),
    .r_addr   (r_addr),
    .r_din    (r_din),
    .r_we     (r_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One CPU write; returns at the negedge after it has been clocked in
  task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_addr = addr;
    cpu_din  = data;
    cpu_we   = 1'b1;
    @(negedge clk);
    cpu_we   = 1'b0;
  endtask

  // One CPU read with its one-cycle latency
  task automatic cpuRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    cpu_addr = addr;
    cpu_we   = 1'b0;
    @(negedge clk);
    data = cpu_dout;
  endtask

  // Raise vblank and record 40 cycles of renderer traffic, optionally injecting
  // one CPU write when r_addr reaches injectAt and reading STATUS right after it
  task automatic runBurst(input int injectAt, input logic [31:0] injAddr, input logic [31:0] injData);
    int injState;
    injState  = 0;
    beatCount = 0;
    firstBeat = -1;
    midStatus = 32'hFFFF_FFFF;
    busyAt32  = 1'bx;
    busyAt33  = 1'bx;
    for (int i = 0; i < 32; i++) begin
      seenValid[i] = 1'b0;
      seenData[i]  = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    vblank = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      cpu_we = 1'b0;
      if (r_we === 1'b1) begin
        if (firstBeat < 0) firstBeat = cyc;
        if (beatCount < 64) begin
          beatAddr[beatCount] = r_addr;
          beatData[beatCount] = r_din;
        end
        if (r_addr < 32) begin
          seenValid[r_addr[4:0]] = 1'b1;
          seenData[r_addr[4:0]]  = r_din;
        end
        beatCount++;
      end
      if (cyc == 32) busyAt32 = busy;
      if (cyc == 33) busyAt33 = busy;
      if (injState == 2) begin
        midStatus = cpu_dout;
        injState  = 3;
      end else if (injState == 1) begin
        cpu_addr = CTRL_ADDR;
        injState = 2;
      end else if (injectAt >= 0 && injState == 0 && r_addr == 32'(injectAt)) begin
        cpu_addr = injAddr;
        cpu_din  = injData;
        cpu_we   = 1'b1;
        injState = 1;
      end
    end
    vblank = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int spurious;
    rst = 1'b1; vblank = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_din = 32'd0;
    repeat (3) @(negedge clk);
    assertCount++;
    if (r_we !== 1'b0) begin failCount++; $display("[TB] FAIL reset_r_we: got %b expected 0", r_we); end
    assertCount++;
    if (r_addr !== 32'd0) begin failCount++; $display("[TB] FAIL reset_r_addr: got %h expected 0", r_addr); end
    assertCount++;
    if (r_din !== 32'd0) begin failCount++; $display("[TB] FAIL reset_r_din: got %h expected 0", r_din); end
    assertCount++;
    if (cpu_dout !== 32'd0) begin failCount++; $display("[TB] FAIL reset_cpu_dout: got %h expected 0", cpu_dout); end
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (r_we !== 1'b0) spurious++;
    end
    assertCount++;
    if (spurious !== 0) begin failCount++; $display("[TB] FAIL reset_no_copy_before_blank: got %0d beats expected 0", spurious); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0001) begin failCount++; $display("[TB] FAIL reset_status: got %h expected 00000001", rd); end
  endtask

  task automatic test_reset_burst();
    logic [31:0] rd;
    runBurst(-1, 32'd0, 32'd0);
    assertCount++;
    if (beatCount !== 32) begin failCount++; $display("[TB] FAIL rstburst_count: got %0d expected 32", beatCount); end
    assertCount++;
    if (firstBeat !== 1) begin failCount++; $display("[TB] FAIL rstburst_latency: got %0d expected 1", firstBeat); end
    for (int k = 0; k < 32; k++) begin
      if (k < beatCount) begin
        assertCount++;
        if (beatAddr[k] !== 32'(k)) begin failCount++; $display("[TB] FAIL rstburst_addr[%0d]: got %h expected %h", k, beatAddr[k], k); end
        assertCount++;
        if (beatData[k] !== 32'd0) begin failCount++; $display("[TB] FAIL rstburst_data[%0d]: got %h expected 0", k, beatData[k]); end
      end
    end
    assertCount++;
    if (busyAt32 !== 1'b1) begin failCount++; $display("[TB] FAIL rstburst_busy_last_beat: got %b expected 1", busyAt32); end
    assertCount++;
    if (busyAt33 !== 1'b0) begin failCount++; $display("[TB] FAIL rstburst_busy_after: got %b expected 0", busyAt33); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0100) begin failCount++; $display("[TB] FAIL rstburst_status: got %h expected 00000100", rd); end
  endtask

  task automatic test_slot_write();
    logic [31:0] rd;
    logic [31:0] slot5;
    logic [31:0] slot6;
    slot5 = {6'd0, 4'd5, 11'd200, 11'd200};
    slot6 = {6'd0, 4'd9, 11'd17, 11'd33};
    cpuWrite(32'd5, slot5);
    cpuRead(32'd5, rd);
    assertCount++;
    if (rd !== slot5) begin failCount++; $display("[TB] FAIL slot_readback: got %h expected %h", rd, slot5); end
    @(negedge clk);
    cpu_addr = 32'd6; cpu_din = slot6; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    rd = cpu_dout;
    assertCount++;
    if (rd !== 32'd0) begin failCount++; $display("[TB] FAIL slot_read_during_write: got %h expected 0", rd); end
    @(negedge clk);
    rd = cpu_dout;
    assertCount++;
    if (rd !== slot6) begin failCount++; $display("[TB] FAIL slot_read_after_write: got %h expected %h", rd, slot6); end
    cpuWrite(CTRL_ADDR, 32'h1);
    runBurst(-1, 32'd0, 32'd0);
    assertCount++;
    if (beatCount !== (DIRTY_MODE ? 2 : 32)) begin failCount++; $display("[TB] FAIL slot_burst_count: got %0d expected %0d", beatCount, DIRTY_MODE ? 2 : 32); end
    assertCount++;
    if (seenData[5] !== slot5) begin failCount++; $display("[TB] FAIL slot5_burst_data: got %h expected %h", seenData[5], slot5); end
    assertCount++;
    if (seenData[6] !== slot6) begin failCount++; $display("[TB] FAIL slot6_burst_data: got %h expected %h", seenData[6], slot6); end
    for (int i = 0; i < 32; i++) begin
      if (seenValid[i] && i != 5 && i != 6) begin
        assertCount++;
        if (seenData[i] !== 32'd0) begin failCount++; $display("[TB] FAIL slot_other_data[%0d]: got %h expected 0", i, seenData[i]); end
      end
    end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0200) begin failCount++; $display("[TB] FAIL slot_status: got %h expected 00000200", rd); end
  endtask

  task automatic test_commit_mid_blank();
    logic [31:0] rd;
    int spurious;
    @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    cpuWrite(CTRL_ADDR, 32'h1);
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (r_we !== 1'b0) spurious++;
    end
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL midblank_pending_busy: got %b expected 1", busy); end
    vblank = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (r_we !== 1'b0) spurious++;
    end
    assertCount++;
    if (spurious !== 0) begin failCount++; $display("[TB] FAIL midblank_no_early_copy: got %0d beats expected 0", spurious); end
    runBurst(-1, 32'd0, 32'd0);
    assertCount++;
    if (beatCount !== (DIRTY_MODE ? 0 : 32)) begin failCount++; $display("[TB] FAIL midblank_burst_count: got %0d expected %0d", beatCount, DIRTY_MODE ? 0 : 32); end
    assertCount++;
    if (busyAt32 !== 1'b1) begin failCount++; $display("[TB] FAIL midblank_busy_last_beat: got %b expected 1", busyAt32); end
    assertCount++;
    if (busyAt33 !== 1'b0) begin failCount++; $display("[TB] FAIL midblank_busy_after: got %b expected 0", busyAt33); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0300) begin failCount++; $display("[TB] FAIL midblank_status: got %h expected 00000300", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    logic [31:0] oldVal;
    logic [31:0] newVal;
    oldVal = {6'd0, 4'd2, 11'd100, 11'd50};
    newVal = {6'd0, 4'd7, 11'd1, 11'd2};
    cpuWrite(32'd3, oldVal);
    cpuWrite(CTRL_ADDR, 32'h1);
    runBurst(10, 32'd3, newVal);
    assertCount++;
    if (seenData[3] !== oldVal) begin failCount++; $display("[TB] FAIL overrun_burst_slot3: got %h expected %h", seenData[3], oldVal); end
    assertCount++;
    if (beatCount !== (DIRTY_MODE ? 1 : 32)) begin failCount++; $display("[TB] FAIL overrun_burst_count: got %0d expected %0d", beatCount, DIRTY_MODE ? 1 : 32); end
    assertCount++;
    if (midStatus !== 32'h0000_0305) begin failCount++; $display("[TB] FAIL overrun_mid_status: got %h expected 00000305", midStatus); end
    cpuRead(32'd3, rd);
    assertCount++;
    if (rd !== oldVal) begin failCount++; $display("[TB] FAIL overrun_write_dropped: got %h expected %h", rd, oldVal); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0404) begin failCount++; $display("[TB] FAIL overrun_sticky: got %h expected 00000404", rd); end
    cpuWrite(CTRL_ADDR, 32'h2);
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0400) begin failCount++; $display("[TB] FAIL overrun_clear: got %h expected 00000400", rd); end
  endtask

  task automatic test_commit_during_copy();
    logic [31:0] rd;
    cpuWrite(CTRL_ADDR, 32'h1);
    runBurst(5, CTRL_ADDR, 32'h1);
    assertCount++;
    if (midStatus !== 32'h0000_0403) begin failCount++; $display("[TB] FAIL again_mid_status: got %h expected 00000403", midStatus); end
    assertCount++;
    if (busyAt33 !== 1'b1) begin failCount++; $display("[TB] FAIL again_busy_after_first: got %b expected 1", busyAt33); end
    assertCount++;
    if (beatCount !== (DIRTY_MODE ? 0 : 32)) begin failCount++; $display("[TB] FAIL again_first_count: got %0d expected %0d", beatCount, DIRTY_MODE ? 0 : 32); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0501) begin failCount++; $display("[TB] FAIL again_between_status: got %h expected 00000501", rd); end
    runBurst(-1, 32'd0, 32'd0);
    assertCount++;
    if (beatCount !== (DIRTY_MODE ? 0 : 32)) begin failCount++; $display("[TB] FAIL again_second_count: got %0d expected %0d", beatCount, DIRTY_MODE ? 0 : 32); end
    assertCount++;
    if (busyAt33 !== 1'b0) begin failCount++; $display("[TB] FAIL again_busy_after_second: got %b expected 0", busyAt33); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0600) begin failCount++; $display("[TB] FAIL again_final_status: got %h expected 00000600", rd); end
  endtask

`ifdef SPRITE_DIRTY_SKIP_EN
  task automatic test_dirty_skip();
    logic [31:0] rd;
    logic [31:0] valA;
    logic [31:0] valB;
    valA = {6'd0, 4'd1, 11'd10, 11'd20};
    valB = {6'd0, 4'd15, 11'd2047, 11'd479};
    cpuWrite(32'd2, valA);
    cpuWrite(32'd30, valB);
    cpuWrite(CTRL_ADDR, 32'h1);
    runBurst(-1, 32'd0, 32'd0);
    assertCount++;
    if (beatCount !== 2) begin failCount++; $display("[TB] FAIL dirty_count: got %0d expected 2", beatCount); end
    assertCount++;
    if (beatAddr[0] !== 32'd2) begin failCount++; $display("[TB] FAIL dirty_first_addr: got %h expected 2", beatAddr[0]); end
    assertCount++;
    if (beatData[0] !== valA) begin failCount++; $display("[TB] FAIL dirty_first_data: got %h expected %h", beatData[0], valA); end
    assertCount++;
    if (beatAddr[1] !== 32'd30) begin failCount++; $display("[TB] FAIL dirty_second_addr: got %h expected 1e", beatAddr[1]); end
    assertCount++;
    if (beatData[1] !== valB) begin failCount++; $display("[TB] FAIL dirty_second_data: got %h expected %h", beatData[1], valB); end
    assertCount++;
    if (busyAt32 !== 1'b1) begin failCount++; $display("[TB] FAIL dirty_busy_last_beat: got %b expected 1", busyAt32); end
    assertCount++;
    if (busyAt33 !== 1'b0) begin failCount++; $display("[TB] FAIL dirty_busy_after: got %b expected 0", busyAt33); end
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0700) begin failCount++; $display("[TB] FAIL dirty_status: got %h expected 00000700", rd); end
  endtask
`endif

  task automatic test_reset_mid_copy();
    logic [31:0] rd;
    cpuWrite(CTRL_ADDR, 32'h1);
    @(negedge clk);
    vblank = 1'b1;
    repeat (5) @(negedge clk);
    assertCount++;
    if (r_addr !== 32'd4) begin failCount++; $display("[TB] FAIL abort_precheck_addr: got %h expected 4", r_addr); end
    rst = 1'b1;
    vblank = 1'b0;
    @(negedge clk);
    assertCount++;
    if (r_we !== 1'b0) begin failCount++; $display("[TB] FAIL abort_r_we: got %b expected 0", r_we); end
    assertCount++;
    if (r_addr !== 32'd0) begin failCount++; $display("[TB] FAIL abort_r_addr: got %h expected 0", r_addr); end
    rst = 1'b0;
    cpuRead(CTRL_ADDR, rd);
    assertCount++;
    if (rd !== 32'h0000_0001) begin failCount++; $display("[TB] FAIL abort_status: got %h expected 00000001", rd); end
  endtask

  initial begin
    test_reset();
    test_reset_burst();
    test_slot_write();
    test_commit_mid_blank();
    test_overrun();
    test_commit_during_copy();
`ifdef SPRITE_DIRTY_SKIP_EN
    test_dirty_skip();
`endif
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
